// File: rtl/run_seq_detector_pkg.sv
// Shared defaults and types for the run-sequence detector.
// The default reset pattern is elements 1,2,3, with element k at bits [k*SYM_W +: SYM_W].
package run_seq_detector_pkg;

  localparam int DEF_SYM_W = 2;
  localparam int DEF_DEPTH = 3;
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_SYM_W-1:0]           DEF_NULL_SYM      = '0;
  localparam logic [DEF_DEPTH*DEF_SYM_W-1:0] DEF_RESET_PATTERN = 6'b11_10_01;

  // Listed in priority order. The first rule that matches decides the next stage.
  typedef enum logic [2:0] {
    RULE_STAY_RUN  = 3'd0,
    RULE_ADVANCE   = 3'd1,
    RULE_RESTART   = 3'd2,
    RULE_NULL_HOLD = 3'd3,
    RULE_CLEAR     = 3'd4
  } step_rule_e;

endpackage

// File: rtl/run_seq_detector_sat_counter.sv
// Saturating up-counter with a clear input. When clear and increment occur in the same
// cycle, the clear takes priority. The count stops at all-ones.
module sat_counter
  import run_seq_detector_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/run_seq_detector.sv
// Detects a programmable DEPTH-element pattern in a symbol stream. Each element of the
// pattern may appear as a run of one or more repeats. NULL_SYM holds a partial match.
module run_seq_detector
  import run_seq_detector_pkg::*;
#(
  parameter int                     SYM_W         = DEF_SYM_W,
  parameter int                     DEPTH         = DEF_DEPTH,
  parameter int                     CNT_W         = DEF_CNT_W,
  parameter logic [SYM_W-1:0]       NULL_SYM      = '0,
  parameter logic [DEPTH*SYM_W-1:0] RESET_PATTERN = DEF_RESET_PATTERN,
  localparam int                    SW            = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [DEPTH*SYM_W-1:0]   cfg_pattern,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_sym,
  input  logic                     cnt_clr,
  output logic                     ans,
  output logic                     match_pulse,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [SW-1:0]            stage
);

  localparam logic [SW-1:0] STAGE_FULL = SW'(DEPTH);

  logic [DEPTH*SYM_W-1:0] pattern_q, pattern_d;
  logic [SW-1:0]          stage_q, stage_d, stage_step;
  logic                   match_pulse_q, match_pulse_d;
  logic                   hit;

  logic [SYM_W-1:0]       elem [DEPTH];
  logic [SYM_W-1:0]       sym_cur, sym_nxt;
  logic                   in_run, mid_run;
  step_rule_e             rule;

  // sym_cur is the element whose run we are currently inside.
  // sym_nxt is the element that would advance the match by one stage.
  always_comb begin
    sym_cur = '0;
    sym_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      elem[k] = pattern_q[k*SYM_W +: SYM_W];
      if (int'(stage_q) == k + 1) sym_cur = elem[k];
      if (int'(stage_q) == k)     sym_nxt = elem[k];
    end
  end

  assign in_run  = (stage_q != '0);
  assign mid_run = in_run && (stage_q != STAGE_FULL);

  // NOTE: every always_comb output gets a default on entry, so no path can infer a latch.
  always_comb begin
    rule = RULE_CLEAR;
    if (in_run && (in_sym == sym_cur)) begin
      rule = RULE_STAY_RUN;
    end else if (mid_run && (in_sym == sym_nxt)) begin
      rule = RULE_ADVANCE;
    end else if (in_sym == elem[0]) begin
      rule = RULE_RESTART;
    end else if (mid_run && (in_sym == NULL_SYM)) begin
      rule = RULE_NULL_HOLD;
    end
  end

  always_comb begin
    stage_step = '0;
    unique case (rule)
      RULE_STAY_RUN,
      RULE_NULL_HOLD: stage_step = stage_q;
      RULE_ADVANCE:   stage_step = stage_q + SW'(1);
      RULE_RESTART:   stage_step = SW'(1);
      default:        stage_step = '0;
    endcase
  end

  // A pattern load takes priority over the input symbol and restarts matching from zero.
  always_comb begin
    pattern_d = pattern_q;
    stage_d   = stage_q;
    if (cfg_we) begin
      pattern_d = cfg_pattern;
      stage_d   = '0;
    end else if (in_valid) begin
      stage_d = stage_step;
    end
    hit           = (stage_d == STAGE_FULL) && (stage_q != STAGE_FULL);
    match_pulse_d = hit;
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q     <= RESET_PATTERN;
      stage_q       <= '0;
      match_pulse_q <= 1'b0;
    end else begin
      pattern_q     <= pattern_d;
      stage_q       <= stage_d;
      match_pulse_q <= match_pulse_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (cnt_clr),
    .q     (match_cnt)
  );

  assign stage       = stage_q;
  assign ans         = (stage_q == STAGE_FULL);
  assign match_pulse = match_pulse_q;

endmodule

// File: tb/tb_run_seq_detector.sv
// Scoreboard bench for run_seq_detector: a default instance and a CNT_W=2 instance.
// Both share one input stream. Expectations are queued at drive time and popped one cycle later.
module tb_run_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [5:0] cfg_pattern;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       cnt_clr;

  logic       ans_a,   pulse_a;
  logic [7:0] cnt_a;
  logic [1:0] stage_a;
  logic       ans_b,   pulse_b;
  logic [1:0] cnt_b;
  logic [1:0] stage_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [1:0] stage;
    logic       pulse;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  run_seq_detector u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .in_valid    (in_valid),
    .in_sym      (in_sym),
    .cnt_clr     (cnt_clr),
    .ans         (ans_a),
    .match_pulse (pulse_a),
    .match_cnt   (cnt_a),
    .stage       (stage_a)
  );

  run_seq_detector #(.CNT_W(2)) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .in_valid    (in_valid),
    .in_sym      (in_sym),
    .cnt_clr     (cnt_clr),
    .ans         (ans_b),
    .match_pulse (pulse_b),
    .match_cnt   (cnt_b),
    .stage       (stage_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Pops one expectation and compares it against both instances.
  // Instance b has a 2-bit counter, so its expected count saturates at 3.
  task automatic score();
    exp_t       e;
    logic [1:0] cnt_b_exp;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e         = sb.pop_front();
      cnt_b_exp = (e.cnt > 8'd3) ? 2'd3 : e.cnt[1:0];
      check({e.tag, ".stage"},   32'(stage_a), 32'(e.stage));
      check({e.tag, ".ans"},     32'(ans_a),   32'(e.stage == 2'd3));
      check({e.tag, ".pulse"},   32'(pulse_a), 32'(e.pulse));
      check({e.tag, ".cnt"},     32'(cnt_a),   32'(e.cnt));
      check({e.tag, ".b_stage"}, 32'(stage_b), 32'(e.stage));
      check({e.tag, ".b_pulse"}, 32'(pulse_b), 32'(e.pulse));
      check({e.tag, ".b_cnt"},   32'(cnt_b),   32'(cnt_b_exp));
    end
  endtask

  task automatic cyc(input string tag, input logic v, input logic [1:0] s,
                     input logic [1:0] es, input logic ep, input logic [7:0] ec);
    exp_t e;
    in_valid = v;
    in_sym   = s;
    e.tag    = tag;
    e.stage  = es;
    e.pulse  = ep;
    e.cnt    = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    score();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    in_valid    = 1'b0;
    in_sym      = '0;
    cnt_clr     = 1'b0;
    cyc("rst0", 1'b0, 2'd0, 2'd0, 1'b0, 8'd0);
    cyc("rst1", 1'b1, 2'd1, 2'd0, 1'b0, 8'd0);
    reset = 1'b0;

    // Pattern 1,2,3 with a repeated middle element.
    cyc("t1_a", 1'b1, 2'd1, 2'd1, 1'b0, 8'd0);
    cyc("t1_b", 1'b1, 2'd2, 2'd2, 1'b0, 8'd0);
    cyc("t1_c", 1'b1, 2'd2, 2'd2, 1'b0, 8'd0);
    cyc("t1_d", 1'b1, 2'd3, 2'd3, 1'b1, 8'd1);

    // Null symbols hold a partial match. Repeats at full depth do not pulse again.
    cyc("t2_a", 1'b1, 2'd1, 2'd1, 1'b0, 8'd1);
    cyc("t2_b", 1'b1, 2'd0, 2'd1, 1'b0, 8'd1);
    cyc("t2_c", 1'b1, 2'd2, 2'd2, 1'b0, 8'd1);
    cyc("t2_d", 1'b1, 2'd0, 2'd2, 1'b0, 8'd1);
    cyc("t2_e", 1'b1, 2'd3, 2'd3, 1'b1, 8'd2);
    cyc("t2_f", 1'b1, 2'd3, 2'd3, 1'b0, 8'd2);
    cyc("t2_g", 1'b1, 2'd3, 2'd3, 1'b0, 8'd2);
    cyc("t2_h", 1'b1, 2'd0, 2'd0, 1'b0, 8'd2);

    // Restart on the first element, including in the middle of a partial match.
    cyc("t3_a", 1'b1, 2'd1, 2'd1, 1'b0, 8'd2);
    cyc("t3_b", 1'b1, 2'd1, 2'd1, 1'b0, 8'd2);
    cyc("t3_c", 1'b1, 2'd2, 2'd2, 1'b0, 8'd2);
    cyc("t3_d", 1'b1, 2'd1, 2'd1, 1'b0, 8'd2);
    cyc("t3_e", 1'b1, 2'd2, 2'd2, 1'b0, 8'd2);
    cyc("t3_f", 1'b1, 2'd3, 2'd3, 1'b1, 8'd3);
    cyc("t3_g", 1'b1, 2'd1, 2'd1, 1'b0, 8'd3);
    cyc("t3_h", 1'b1, 2'd3, 2'd0, 1'b0, 8'd3);

    // Cycles with in_valid low are ignored, even though a symbol is present on the bus.
    cyc("t4_a", 1'b1, 2'd1, 2'd1, 1'b0, 8'd3);
    cyc("t4_g", 1'b0, 2'd3, 2'd1, 1'b0, 8'd3);
    cyc("t4_b", 1'b1, 2'd2, 2'd2, 1'b0, 8'd3);
    cyc("t4_h", 1'b0, 2'd3, 2'd2, 1'b0, 8'd3);
    cyc("t4_i", 1'b0, 2'd1, 2'd2, 1'b0, 8'd3);
    cyc("t4_c", 1'b1, 2'd3, 2'd3, 1'b1, 8'd4);
    cyc("t4_j", 1'b0, 2'd0, 2'd3, 1'b0, 8'd4);

    // Load pattern 3,1,2 while at stage 2.
    cyc("t4_k", 1'b1, 2'd1, 2'd1, 1'b0, 8'd4);
    cyc("t4_l", 1'b1, 2'd2, 2'd2, 1'b0, 8'd4);
    cfg_we      = 1'b1;
    cfg_pattern = 6'b10_01_11;
    cyc("cfg",  1'b1, 2'd3, 2'd0, 1'b0, 8'd4);
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cyc("n_a",  1'b1, 2'd3, 2'd1, 1'b0, 8'd4);
    cyc("n_b",  1'b1, 2'd1, 2'd2, 1'b0, 8'd4);
    cyc("n_c",  1'b1, 2'd2, 2'd3, 1'b1, 8'd5);
    cyc("o_a",  1'b1, 2'd1, 2'd0, 1'b0, 8'd5);
    cyc("o_b",  1'b1, 2'd2, 2'd0, 1'b0, 8'd5);
    cyc("o_c",  1'b1, 2'd3, 2'd1, 1'b0, 8'd5);

    // Reset at stage 2 overrides in_valid, cfg_we and the pattern load.
    cyc("r_a",  1'b1, 2'd1, 2'd2, 1'b0, 8'd5);
    reset       = 1'b1;
    cfg_we      = 1'b1;
    cfg_pattern = 6'b10_01_11;
    cyc("r_rst", 1'b1, 2'd3, 2'd0, 1'b0, 8'd0);
    reset       = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cyc("r_b",  1'b1, 2'd1, 2'd1, 1'b0, 8'd0);
    cyc("r_c",  1'b1, 2'd2, 2'd2, 1'b0, 8'd0);
    cyc("r_d",  1'b1, 2'd3, 2'd3, 1'b1, 8'd1);

    // cnt_clr in the same cycle as a match: the clear wins, and the pulse still fires.
    cyc("c_a",  1'b1, 2'd1, 2'd1, 1'b0, 8'd1);
    cyc("c_b",  1'b1, 2'd2, 2'd2, 1'b0, 8'd1);
    cnt_clr = 1'b1;
    cyc("c_clr", 1'b1, 2'd3, 2'd3, 1'b1, 8'd0);
    cnt_clr = 1'b0;
    cyc("c_d",  1'b1, 2'd3, 2'd3, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
